// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the pushbutton conditioner: FSM state encoding
// and the ms-to-clock-cycles conversion used to size the debounce/long-press timers.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  // 64-bit intermediate keeps e.g. 100 MHz * 2000 ms from overflowing; result floors at 1.
  function automatic int unsigned ms_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned ms);
    longint unsigned cycles;
    cycles = (clk_hz * ms) / 64'd1000;
    return (cycles < 64'd1) ? 32'd1 : 32'(cycles);
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced pushbutton front end: level, press/release strobes and a sticky pedestrian request.
// Optional long-press strobe is built only when BUTTON_LONG_PRESS_EN is defined.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_TIME_MS = 10,
  parameter int unsigned LONG_PRESS_MS    = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  input  logic req_ack,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic ped_req,
  output logic long_press_pulse
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(DEBOUNCE_TIME_MS));
  localparam int unsigned LP_CYCLES = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(LONG_PRESS_MS));
  localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);
  // The sample that enters a CHK state and the sample that leaves it both count toward DB_CYCLES.
  localparam int unsigned DB_LAST   = (DB_CYCLES > 2) ? (DB_CYCLES - 2) : 0;
  localparam bit          DB_SINGLE = (DB_CYCLES == 1);

  if (LP_CYCLES <= DB_CYCLES) begin : g_cfg_check
    $error("LONG_PRESS_MS must give more cycles than DEBOUNCE_TIME_MS");
  end

  logic            btn_sync_n;
  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_done_c;
  logic            press_d, release_d, level_d, ped_req_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_n),
    .q   (btn_sync_n)
  );

  assign db_done_c = (db_cnt_q >= DB_W'(DB_LAST));

  always_ff @(posedge clk) begin
    if (rst) state_q <= RELEASED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RELEASED:    if (!btn_sync_n) state_d = DB_SINGLE ? HELD : PRESS_CHK;
      PRESS_CHK:   if (btn_sync_n)  state_d = RELEASED;
                   else if (db_done_c) state_d = HELD;
      HELD:        if (btn_sync_n)  state_d = DB_SINGLE ? RELEASED : RELEASE_CHK;
      RELEASE_CHK: if (!btn_sync_n) state_d = HELD;
                   else if (db_done_c) state_d = RELEASED;
      default:     state_d = RELEASED;
    endcase
  end

  // Aborted checks (CHK -> origin state) produce no strobe and leave the level alone.
  always_comb begin
    db_cnt_d  = '0;
    press_d   = (state_d == HELD)     && (state_q == PRESS_CHK   || state_q == RELEASED);
    release_d = (state_d == RELEASED) && (state_q == RELEASE_CHK || state_q == HELD);
    level_d   = btn_level;
    if ((state_q == PRESS_CHK || state_q == RELEASE_CHK) && state_d == state_q) begin
      db_cnt_d = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + DB_W'(1);
    end
    if (press_d)   level_d = 1'b1;
    if (release_d) level_d = 1'b0;
    // An ack landing in the press strobe cycle is stale; the new press keeps the request.
    ped_req_d = press_d | (ped_req & ~(req_ack & ~press_pulse));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      ped_req       <= 1'b0;
    end else begin
      db_cnt_q      <= db_cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      ped_req       <= ped_req_d;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LP_W = $clog2(LP_CYCLES + 1);

  logic [LP_W-1:0] lp_cnt_q;
  logic            lp_pulse_q;

  // Counts cycles spent in HELD; saturates at LP_CYCLES so the strobe fires once per hold.
  always_ff @(posedge clk) begin
    if (rst || state_q != HELD) begin
      lp_cnt_q   <= '0;
      lp_pulse_q <= 1'b0;
    end else begin
      lp_pulse_q <= (lp_cnt_q == LP_W'(LP_CYCLES - 1));
      if (lp_cnt_q != LP_W'(LP_CYCLES)) lp_cnt_q <= lp_cnt_q + LP_W'(1);
    end
  end

  assign long_press_pulse = lp_pulse_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule
